// File: rtl/hilbert_mux_seq.sv
// Time-multiplexed antisymmetric (type III) Hilbert FIR: one pre-subtractor, multiplier and accumulator shared by every tap and channel.
// Define HILBERT_COEF_WR_EN to make the coefficients writable at run time through the coef_* ports.
module hilbert_mux_seq #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int ORDER = 8,
    parameter int CW    = 11,
    parameter int CFRAC = 10,
    parameter logic [(ORDER/4)*CW-1:0] COEFS = {11'd245, 11'd641}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*DW-1:0] in_data,
    output logic              out_valid,
    output logic [NCH*DW-1:0] re_out,
    output logic [NCH*DW-1:0] im_out,
    output logic              overrun
`ifdef HILBERT_COEF_WR_EN
    ,
    input  logic              coef_we,
    input  logic [4:0]        coef_addr,
    input  logic [CW-1:0]     coef_data
`endif
);

    localparam int K   = ORDER / 4;
    localparam int CTR = ORDER / 2;
    localparam int PW  = DW + 1;
    localparam int MW  = PW + CW;
    localparam int AW  = MW + $clog2(K);
    localparam int RW  = AW + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int JW  = (K > 1) ? $clog2(K) : 1;

    localparam logic signed [RW-1:0] HALF   = RW'(1) <<< (CFRAC - 1);
    localparam logic signed [RW-1:0] HALF_M = HALF - RW'(1);
    localparam logic signed [RW-1:0] SMAX   = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] SMIN   = -SMAX - RW'(1);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;

    state_t           state, state_nxt;
    logic [CHW-1:0]   ch, ch_nxt;
    logic [JW-1:0]    j, j_nxt;

    logic signed [DW-1:0] xd [NCH][ORDER+1];
    logic signed [DW-1:0] xs [ORDER+1];
    logic signed [CW-1:0] coef [K];

    logic signed [DW-1:0] tap_a_p0, tap_b_p0;
    logic signed [CW-1:0] cf_p0;
    logic signed [PW-1:0] pre_p0;
    logic signed [MW-1:0] prod_p0;
    logic signed [AW-1:0] acc_p1;
    logic signed [DW-1:0] rnd_p1;

    logic [NCH*DW-1:0] re_sh, im_sh, re_nxt, im_nxt;

    // Scale by 2^-CFRAC, round half away from zero, clamp to the DW-bit range.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [RW-1:0] t;
        t = RW'(a) + (a[AW-1] ? HALF_M : HALF);
        t = t >>> CFRAC;
        if (t > SMAX)
            return DW'(SMAX);
        else if (t < SMIN)
            return DW'(SMIN);
        else
            return DW'(t);
    endfunction

`ifdef HILBERT_COEF_WR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < K; i++)
                coef[i] <= COEFS[i*CW +: CW];
        end else if (state == IDLE && coef_we) begin
            for (int i = 0; i < K; i++)
                if (coef_addr == 5'(i))
                    coef[i] <= coef_data;
        end
    end
`else
    for (genvar g = 0; g < K; g++) begin : g_coef
        assign coef[g] = COEFS[g*CW +: CW];
    end
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE) && !reset;

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        j_nxt     = j;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = MAC;
                    ch_nxt    = '0;
                    j_nxt     = '0;
                end
            end
            MAC: begin
                if (j == JW'(K - 1))
                    state_nxt = ROUND;
                else
                    j_nxt = j + JW'(1);
            end
            ROUND: begin
                j_nxt = '0;
                if (ch == CHW'(NCH - 1)) begin
                    state_nxt = DONE;
                end else begin
                    ch_nxt    = ch + CHW'(1);
                    state_nxt = MAC;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ch      <= '0;
            j       <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            j     <= j_nxt;
            if (in_valid && !in_ready)
                overrun <= 1'b1;
        end
    end

    // Stage p0: select channel and tap pair, pre-subtract, multiply.
    always_comb begin
        for (int t = 0; t <= ORDER; t++)
            xs[t] = '0;
        for (int c = 0; c < NCH; c++)
            if (ch == CHW'(c))
                for (int t = 0; t <= ORDER; t++)
                    xs[t] = xd[c][t];
    end

    always_comb begin
        tap_a_p0 = '0;
        tap_b_p0 = '0;
        cf_p0    = '0;
        for (int jj = 0; jj < K; jj++)
            if (j == JW'(jj)) begin
                tap_a_p0 = xs[CTR-1-2*jj];
                tap_b_p0 = xs[CTR+1+2*jj];
                cf_p0    = coef[jj];
            end
    end

    assign pre_p0  = PW'(tap_a_p0) - PW'(tap_b_p0);
    assign prod_p0 = MW'(pre_p0) * MW'(cf_p0);

    // Stage p1: accumulate, then round/saturate the finished channel.
    assign rnd_p1 = round_sat(acc_p1);

    always_comb begin
        re_nxt = re_sh;
        im_nxt = im_sh;
        for (int c = 0; c < NCH; c++)
            if (ch == CHW'(c)) begin
                re_nxt[c*DW +: DW] = xs[CTR];
                im_nxt[c*DW +: DW] = rnd_p1;
            end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t <= ORDER; t++)
                    xd[c][t] <= '0;
            acc_p1 <= '0;
            re_out <= '0;
            im_out <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int t = ORDER; t > 0; t--)
                        xd[c][t] <= xd[c][t-1];
                    xd[c][0] <= in_data[c*DW +: DW];
                end
            end
            if (state == MAC)
                acc_p1 <= acc_p1 + AW'(prod_p0);
            if (state == ROUND) begin
                acc_p1 <= '0;
                // The last channel goes straight to the outputs so they are new in the DONE cycle.
                if (ch == CHW'(NCH - 1)) begin
                    re_out <= re_nxt;
                    im_out <= im_nxt;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == ROUND) begin
            re_sh <= re_nxt;
            im_sh <= im_nxt;
        end
    end

endmodule
